interrupt_sequencer: RTL

Sequences the 6502 reset, NMI and IRQ entry: stack pushes of PCH, PCL and P, setting the I flag, and the two-byte vector fetch into the PC.
Sits beside instruction_decode. It samples requests at instruction boundaries and holds decode off (busy) while it drives the address, stack and PC controls.
Priority is reset > NMI > IRQ. NMI is edge-triggered; IRQ is level-triggered and masked by I.

---
 rtl/interrupt_sequencer_pkg.sv | 46 ++++
 rtl/nmi_edge_detect.sv | 26 ++
 rtl/interrupt_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants and types for the 6502 interrupt/reset sequencer.
// Vector addresses, stack page, push-source and interrupt-kind encodings.
package interrupt_sequencer_pkg;

    localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;
    localparam logic [15:0] DEF_NMI_VECTOR = 16'hFFFA;
    localparam logic [15:0] DEF_RES_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VECTOR = 16'hFFFE;

    localparam logic [1:0] PUSH_NONE = 2'b00;
    localparam logic [1:0] PUSH_PCH  = 2'b01;
    localparam logic [1:0] PUSH_PCL  = 2'b10;
    localparam logic [1:0] PUSH_P    = 2'b11;

    typedef enum logic [1:0] {
        KIND_RESET = 2'd0,
        KIND_NMI   = 2'd1,
        KIND_IRQ   = 2'd2
    } kind_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_RST_HOLD,
        S_PUSH_PCH,
        S_PUSH_PCL,
        S_PUSH_P,
        S_VEC_LO,
        S_VEC_HI
    } state_t;

    // Data-out source for a push state; only stack writes drive data.
    function automatic logic [1:0] push_code(state_t s, logic wr);
        logic [1:0] c;
        c = PUSH_NONE;
        if (wr) begin
            case (s)
                S_PUSH_PCH: c = PUSH_PCH;
                S_PUSH_PCL: c = PUSH_PCL;
                S_PUSH_P:   c = PUSH_P;
                default:    c = PUSH_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Falling-edge detector for the active-low NMI line.
// Holds the pending flag until the sequencer consumes it.
module nmi_edge_detect (
    input  logic clk,
    input  logic res,
    input  logic nmi,
    input  logic clear,
    output logic pending
);

    logic nmi_prev;

    // Track last NMI level and latch a 1->0 transition as pending.
    // A fresh edge outranks a same-cycle consume of an older one.
    always_ff @(posedge clk) begin
        nmi_prev <= nmi;
        if (res) begin
            pending <= 1'b0;
        end else if (nmi_prev && !nmi) begin
            pending <= 1'b1;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ entry sequencer: three stack cycles then vector fetch.
// Runs beside decode; owns the bus while busy is high.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE = DEF_STACK_PAGE,
    parameter logic [15:0] NMI_VECTOR = DEF_NMI_VECTOR,
    parameter logic [15:0] RES_VECTOR = DEF_RES_VECTOR,
    parameter logic [15:0] IRQ_VECTOR = DEF_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        irq,
    input  logic        nmi,
    input  logic        i_flag,
    input  logic        sync,
    input  logic [7:0]  stack_pointer,
    output logic        busy,
    output logic [15:0] memory_address,
    output logic        rw,
    output logic [1:0]  push_select,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pc_load_lo,
    output logic        pc_load_hi,
    output logic        done
);

    state_t      state;
    kind_t       kind;
    kind_t       kind_eff;
    logic [7:0]  sp_int;
    logic        nmi_pending;
    logic        nmi_clear;
    logic        in_push;
    logic        hijack;
    logic        take_nmi;
    logic        take_irq;
    logic        push_wr;
    logic [15:0] vec;

    nmi_edge_detect u_nmi (
        .clk     (clk),
        .res     (res),
        .nmi     (nmi),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    // Entry decisions, NMI hijack of an IRQ, and vector choice.
    always_comb begin
        in_push  = (state == S_PUSH_PCH) || (state == S_PUSH_PCL)
                || (state == S_PUSH_P);
        hijack   = !res && rdy && in_push
                && (kind == KIND_IRQ) && nmi_pending;
        take_nmi = !res && rdy && (state == S_WAIT)
                && sync && nmi_pending;
        take_irq = !res && rdy && (state == S_WAIT)
                && sync && !nmi_pending && !irq && !i_flag;
        nmi_clear = hijack || take_nmi;
        kind_eff  = hijack ? KIND_NMI : kind;
        push_wr   = (kind_eff != KIND_RESET);
        case (kind_eff)
            KIND_NMI: vec = NMI_VECTOR;
            KIND_IRQ: vec = IRQ_VECTOR;
            default:  vec = RES_VECTOR;
        endcase
    end

    // Sequencer FSM; outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (res) begin
            state          <= S_RST_HOLD;
            kind           <= KIND_RESET;
            sp_int         <= 8'h00;
            busy           <= 1'b1;
            memory_address <= 16'h0000;
            rw             <= 1'b1;
            push_select    <= PUSH_NONE;
            sp_dec         <= 1'b0;
            set_i          <= 1'b0;
            pc_load_lo     <= 1'b0;
            pc_load_hi     <= 1'b0;
            done           <= 1'b0;
        end else if (rdy) begin
            case (state)
                S_WAIT: begin
                    if (take_nmi || take_irq) begin
                        state          <= S_PUSH_PCH;
                        kind           <= take_nmi ? KIND_NMI : KIND_IRQ;
                        sp_int         <= stack_pointer - 8'd1;
                        busy           <= 1'b1;
                        memory_address <= {STACK_PAGE, stack_pointer};
                        rw             <= 1'b0;
                        push_select    <= PUSH_PCH;
                        sp_dec         <= 1'b1;
                    end
                end
                S_RST_HOLD: begin
                    state          <= S_PUSH_PCH;
                    sp_int         <= stack_pointer - 8'd1;
                    memory_address <= {STACK_PAGE, stack_pointer};
                    rw             <= 1'b1;
                    push_select    <= PUSH_NONE;
                    sp_dec         <= 1'b1;
                end
                S_PUSH_PCH: begin
                    state          <= S_PUSH_PCL;
                    kind           <= kind_eff;
                    sp_int         <= sp_int - 8'd1;
                    memory_address <= {STACK_PAGE, sp_int};
                    rw             <= !push_wr;
                    push_select    <= push_code(S_PUSH_PCL, push_wr);
                end
                S_PUSH_PCL: begin
                    state          <= S_PUSH_P;
                    kind           <= kind_eff;
                    sp_int         <= sp_int - 8'd1;
                    memory_address <= {STACK_PAGE, sp_int};
                    rw             <= !push_wr;
                    push_select    <= push_code(S_PUSH_P, push_wr);
                end
                S_PUSH_P: begin
                    state          <= S_VEC_LO;
                    kind           <= kind_eff;
                    memory_address <= vec;
                    rw             <= 1'b1;
                    push_select    <= PUSH_NONE;
                    sp_dec         <= 1'b0;
                    set_i          <= 1'b1;
                    pc_load_lo     <= 1'b1;
                end
                S_VEC_LO: begin
                    state          <= S_VEC_HI;
                    memory_address <= vec + 16'd1;
                    set_i          <= 1'b0;
                    pc_load_lo     <= 1'b0;
                    pc_load_hi     <= 1'b1;
                    done           <= 1'b1;
                end
                S_VEC_HI: begin
                    state          <= S_WAIT;
                    busy           <= 1'b0;
                    memory_address <= 16'h0000;
                    rw             <= 1'b1;
                    pc_load_hi     <= 1'b0;
                    done           <= 1'b0;
                end
                default: begin
                    state          <= S_WAIT;
                    busy           <= 1'b0;
                    memory_address <= 16'h0000;
                    rw             <= 1'b1;
                    push_select    <= PUSH_NONE;
                    sp_dec         <= 1'b0;
                    set_i          <= 1'b0;
                    pc_load_lo     <= 1'b0;
                    pc_load_hi     <= 1'b0;
                    done           <= 1'b0;
                end
            endcase
        end
    end

endmodule
